// File: rtl/debounce_pkg.sv
// Shared definitions for the input debouncer: FSM state encoding and default
// synchronizer depth / debounce window.
package debounce_pkg;

    typedef enum logic [1:0] {
        STABLE_LOW  = 2'd0,
        WAIT_HIGH   = 2'd1,
        STABLE_HIGH = 2'd2,
        WAIT_LOW    = 2'd3
    } state_e;

    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 1000;

endpackage

// File: rtl/sync_chain.sv
// N-flop synchronizer for a single asynchronous bit; all flops clear to 0 on
// the asynchronous active-low reset.
module sync_chain
    import debounce_pkg::*;
#(
    parameter int STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/input_debouncer.sv
// Debounces a raw asynchronous input into a clean registered level plus
// one-cycle rise/fall pulses. fall_pulse is only built when DEBOUNCE_FALL_PULSE_EN is defined.
module input_debouncer
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_in,
    output logic q_clean,
    output logic rise_pulse,
    output logic fall_pulse
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             s;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             q_clean_q, q_clean_d;
    logic             rise_q, rise_d;
`ifdef DEBOUNCE_FALL_PULSE_EN
    logic             fall_q, fall_d;
`endif

    sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (raw_in),
        .q_o (s)
    );

    // cnt counts consecutive new-level samples; any opposite sample restarts it.
    always_comb begin
        state_d   = state_q;
        cnt_d     = '0;
        q_clean_d = q_clean_q;
        rise_d    = 1'b0;
`ifdef DEBOUNCE_FALL_PULSE_EN
        fall_d    = 1'b0;
`endif
        case (state_q)
            STABLE_LOW: begin
                if (s) begin
                    state_d = WAIT_HIGH;
                    cnt_d   = CNT_ONE;
                end
            end
            WAIT_HIGH: begin
                if (!s) begin
                    state_d = STABLE_LOW;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = STABLE_HIGH;
                    q_clean_d = 1'b1;
                    rise_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            STABLE_HIGH: begin
                if (!s) begin
                    state_d = WAIT_LOW;
                    cnt_d   = CNT_ONE;
                end
            end
            WAIT_LOW: begin
                if (s) begin
                    state_d = STABLE_HIGH;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = STABLE_LOW;
                    q_clean_d = 1'b0;
`ifdef DEBOUNCE_FALL_PULSE_EN
                    fall_d    = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: state_d = STABLE_LOW;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= STABLE_LOW;
            cnt_q     <= '0;
            q_clean_q <= 1'b0;
            rise_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            q_clean_q <= q_clean_d;
            rise_q    <= rise_d;
        end
    end

`ifdef DEBOUNCE_FALL_PULSE_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fall_q <= 1'b0;
        end else begin
            fall_q <= fall_d;
        end
    end

    assign fall_pulse = fall_q;
`else
    assign fall_pulse = 1'b0;
`endif

    assign q_clean    = q_clean_q;
    assign rise_pulse = rise_q;

endmodule

// File: tb/tb_input_debouncer.sv
// Directed bench for input_debouncer: a short-window instance (N=4) for
// edge-exact timing and a long-window instance (N=1000) for the long hold.
`timescale 1ns/1ps
module tb_input_debouncer;

    logic clk = 1'b0;
    logic rst;
    logic raw_s, raw_l;
    logic q_s, rise_s, fall_s;
    logic q_l, rise_l, fall_l;

    int n_vec = 0;
    int n_err = 0;

`ifdef DEBOUNCE_FALL_PULSE_EN
    localparam bit FALL_EN = 1'b1;
`else
    localparam bit FALL_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    input_debouncer #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .raw_in     (raw_s),
        .q_clean    (q_s),
        .rise_pulse (rise_s),
        .fall_pulse (fall_s)
    );

    input_debouncer #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(1000)) dut_long (
        .clk        (clk),
        .rst        (rst),
        .raw_in     (raw_l),
        .q_clean    (q_l),
        .rise_pulse (rise_l),
        .fall_pulse (fall_l)
    );

    always @(negedge clk) begin
        assert (dut_long.cnt_q <= 10'd999);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input bit q, input bit r, input bit f);
        chk({tag, "_q"},    32'(q_s),    32'(q));
        chk({tag, "_rise"}, 32'(rise_s), 32'(r));
        chk({tag, "_fall"}, 32'(fall_s), 32'(f));
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit pat [7];
        int nrise;
        int nfall;
        int maxc;

        pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        rst   = 1'b0;
        raw_s = 1'b0;
        raw_l = 1'b0;

        // Reset state and quiet idle after release
        #12;
        chk_outs("reset", 1'b0, 1'b0, 1'b0);
        tick;
        tick;
        #4 rst = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick;
            chk_outs($sformatf("idle%0d", k), 1'b0, 1'b0, 1'b0);
        end

        // Clean rise: commit at edge SYNC+N = 6
        raw_s = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick;
            chk_outs($sformatf("rise%0d", k), k >= 6, k == 6, 1'b0);
        end

        // Clean fall
        raw_s = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick;
            chk_outs($sformatf("fall%0d", k), k < 6, 1'b0, (k == 6) && FALL_EN);
        end

        // Glitch: three high cycles is one short of the window
        raw_s = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick;
            if (k == 3) raw_s = 1'b0;
            chk_outs($sformatf("glitch%0d", k), 1'b0, 1'b0, 1'b0);
        end

        // Bounce 1,1,0,1,1,1,1: the 0 restarts the count, commit at edge 9
        raw_s = pat[0];
        for (int k = 1; k <= 12; k++) begin
            tick;
            if (k < 7) raw_s = pat[k];
            chk_outs($sformatf("bounce%0d", k), k >= 9, k == 9, 1'b0);
        end

        // Asynchronous reset while q_clean=1 takes effect before the next edge
        #3 rst = 1'b0;
        #1 chk_outs("arst", 1'b0, 1'b0, 1'b0);
        raw_s = 1'b0;
        tick;
        tick;
        #3 rst = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick;
            chk_outs($sformatf("settle%0d", k), 1'b0, 1'b0, 1'b0);
        end

        // Reset in WAIT_HIGH with cnt=2, then release with raw_in held high
        raw_s = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick;
            chk_outs($sformatf("prewait%0d", k), 1'b0, 1'b0, 1'b0);
        end
        chk("wait_state", 32'(dut.state_q), 32'd1);
        chk("wait_cnt", 32'(dut.cnt_q), 32'd2);
        #2 rst = 1'b0;
        #1 chk_outs("midwait_rst", 1'b0, 1'b0, 1'b0);
        chk("midwait_cnt", 32'(dut.cnt_q), 32'd0);
        tick;
        chk_outs("in_rst", 1'b0, 1'b0, 1'b0);
        #3 rst = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick;
            chk_outs($sformatf("rel%0d", k), k >= 6, k == 6, 1'b0);
        end

        // Long hold on the N=1000 instance
        nrise = 0;
        nfall = 0;
        maxc  = 0;
        raw_l = 1'b1;
        for (int k = 1; k <= 5000; k++) begin
            tick;
            if (rise_l) nrise++;
            if (fall_l) nfall++;
            if (int'(dut_long.cnt_q) > maxc) maxc = int'(dut_long.cnt_q);
            if (k == 1001) chk("long_q_before", 32'(q_l), 32'd0);
            if (k == 1002) begin
                chk("long_q_commit", 32'(q_l), 32'd1);
                chk("long_rise_commit", 32'(rise_l), 32'd1);
            end
        end
        chk("long_rise_count", 32'(nrise), 32'd1);
        chk("long_fall_count", 32'(nfall), 32'd0);
        chk("long_q_final", 32'(q_l), 32'd1);
        chk("long_cnt_max", 32'(maxc), 32'd999);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
